// File: rtl/sqrt_pkg.sv
// Shared types and constants for the integer square-root memory responder.
package sqrt_pkg;

   localparam int unsigned ADDR_W        = 8;
   localparam int unsigned DATA_W        = 8;
   localparam int unsigned DEF_OPND_ADDR = 16;
   localparam int unsigned DEF_RES_ADDR  = 18;

   localparam int unsigned REM_W   = 10;
   localparam int unsigned ROOT_W  = 8;
   localparam int unsigned N_STEPS = 8;
   localparam int unsigned CNT_W   = 3;
   localparam int unsigned OPND_W  = 2 * N_STEPS;

   typedef enum logic [2:0] {
      IDLE,
      RD_HI,
      RD_LO,
      CALC,
      WRITE,
      DONE
   } state_t;

endpackage

// File: rtl/sqrt_step.sv
// One restoring digit step of the binary square root: brings in the next
// operand bit pair and decides the next root bit.
module sqrt_step
   import sqrt_pkg::*;
(
   input  logic [REM_W-1:0]  rem,
   input  logic [ROOT_W-1:0] root,
   input  logic [1:0]        pair,
   output logic [REM_W-1:0]  rem_nxt,
   output logic [ROOT_W-1:0] root_nxt
);

   logic [REM_W-1:0] r_sh;
   logic [REM_W-1:0] trial;

   // Shifted remainder never exceeds REM_W bits because the previous root is at most 7 bits.
   always_comb begin
      r_sh  = REM_W'({rem, pair});
      trial = REM_W'({root, 2'b01});
      if (r_sh >= trial) begin
         rem_nxt  = REM_W'(r_sh - trial);
         root_nxt = ROOT_W'({root, 1'b1});
      end else begin
         rem_nxt  = r_sh;
         root_nxt = ROOT_W'({root, 1'b0});
      end
   end

endmodule

// File: rtl/sqrt_engine.sv
// Start/Ack responder: reads a 16-bit operand from data memory, computes
// floor(sqrt) one digit per cycle and writes the 8-bit root back.
module sqrt_engine
   import sqrt_pkg::*;
#(
   parameter int unsigned AW        = ADDR_W,
   parameter int unsigned DW        = DATA_W,
   parameter int unsigned OPND_ADDR = DEF_OPND_ADDR,
   parameter int unsigned RES_ADDR  = DEF_RES_ADDR
) (
   input  logic          Clk,
   input  logic          Reset,
   input  logic          Start,
   output logic          Ack,
   output logic          Busy,
   output logic [AW-1:0] MemAddr,
   input  logic [DW-1:0] MemRdData,
   output logic          MemWrEn,
   output logic [DW-1:0] MemWrData
);

   state_t              state, state_nxt;
   logic                start_q;
   logic [OPND_W-1:0]   opnd, opnd_nxt;
   logic [ROOT_W-1:0]   root, root_nxt;
   logic [REM_W-1:0]    rem, rem_nxt;
   logic [CNT_W-1:0]    cnt, cnt_nxt;

   logic                launch;
   logic [1:0]          pair;
   logic [REM_W-1:0]    step_rem;
   logic [ROOT_W-1:0]   step_root;

   logic                ack_nxt;
   logic                busy_nxt;
   logic [AW-1:0]       addr_nxt;
   logic                wr_en_nxt;
   logic [DW-1:0]       wr_data_nxt;

   assign launch = Start & ~start_q;
   assign pair   = opnd[{cnt, 1'b0} +: 2];

   sqrt_step u_step (
      .rem      (rem),
      .root     (root),
      .pair     (pair),
      .rem_nxt  (step_rem),
      .root_nxt (step_root)
   );

   // State, datapath and registered outputs; outputs are decoded from the next state.
   always_ff @(posedge Clk) begin
      if (!Reset) begin
         state     <= IDLE;
         start_q   <= 1'b0;
         opnd      <= '0;
         root      <= '0;
         rem       <= '0;
         cnt       <= '0;
         Ack       <= 1'b0;
         Busy      <= 1'b0;
         MemAddr   <= '0;
         MemWrEn   <= 1'b0;
         MemWrData <= '0;
      end else begin
         state     <= state_nxt;
         start_q   <= Start;
         opnd      <= opnd_nxt;
         root      <= root_nxt;
         rem       <= rem_nxt;
         cnt       <= cnt_nxt;
         Ack       <= ack_nxt;
         Busy      <= busy_nxt;
         MemAddr   <= addr_nxt;
         MemWrEn   <= wr_en_nxt;
         MemWrData <= wr_data_nxt;
      end
   end

   // Next-state, datapath update and output decode.
   always_comb begin
      state_nxt   = state;
      opnd_nxt    = opnd;
      root_nxt    = root;
      rem_nxt     = rem;
      cnt_nxt     = cnt;
      ack_nxt     = 1'b0;
      busy_nxt    = 1'b0;
      addr_nxt    = '0;
      wr_en_nxt   = 1'b0;
      wr_data_nxt = '0;

      unique case (state)
         IDLE: if (launch) state_nxt = RD_HI;
         RD_HI: begin
            opnd_nxt[OPND_W-1 -: DW] = MemRdData;
            state_nxt = RD_LO;
         end
         RD_LO: begin
            opnd_nxt[DW-1:0] = MemRdData;
            root_nxt  = '0;
            rem_nxt   = '0;
            cnt_nxt   = CNT_W'(N_STEPS - 1);
            state_nxt = CALC;
         end
         CALC: begin
            rem_nxt  = step_rem;
            root_nxt = step_root;
            cnt_nxt  = CNT_W'(cnt - 1'b1);
            if (cnt == '0) state_nxt = WRITE;
         end
         WRITE: state_nxt = DONE;
         DONE: if (launch) state_nxt = RD_HI;
         default: state_nxt = IDLE;
      endcase

      unique case (state_nxt)
         RD_HI: begin
            busy_nxt = 1'b1;
            addr_nxt = AW'(OPND_ADDR);
         end
         RD_LO: begin
            busy_nxt = 1'b1;
            addr_nxt = AW'(OPND_ADDR + 1);
         end
         CALC: busy_nxt = 1'b1;
         WRITE: begin
            busy_nxt    = 1'b1;
            addr_nxt    = AW'(RES_ADDR);
            wr_en_nxt   = 1'b1;
            wr_data_nxt = DW'(root_nxt);
         end
         DONE: ack_nxt = 1'b1;
         default: ;
      endcase
   end

endmodule

// File: tb/tb_sqrt_engine.sv
// Self-checking bench for sqrt_engine: memory model, launch/timing reference
// model with per-cycle compare, pinned literal results and random operands.
module tb_sqrt_engine;

   localparam int unsigned AW        = 8;
   localparam int unsigned DW        = 8;
   localparam int unsigned OPND_ADDR = 16;
   localparam int unsigned RES_ADDR  = 18;

   logic          Clk = 1'b0;
   logic          Reset;
   logic          Start;
   logic          Ack;
   logic          Busy;
   logic [AW-1:0] MemAddr;
   logic [DW-1:0] MemRdData;
   logic          MemWrEn;
   logic [DW-1:0] MemWrData;

   logic [DW-1:0] mem [256];

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   int wr_count = 0;
   int ack_rise_cyc = 0;
   bit ack_prev = 1'b0;

   // reference model state
   bit m_run = 1'b0;
   bit m_ack = 1'b0;
   bit m_start_prev = 1'b0;
   bit m_valid = 1'b0;
   int m_n = 0;
   int m_root = 0;

   always #5 Clk = ~Clk;

   sqrt_engine #(
      .AW(AW), .DW(DW), .OPND_ADDR(OPND_ADDR), .RES_ADDR(RES_ADDR)
   ) dut (
      .Clk       (Clk),
      .Reset     (Reset),
      .Start     (Start),
      .Ack       (Ack),
      .Busy      (Busy),
      .MemAddr   (MemAddr),
      .MemRdData (MemRdData),
      .MemWrEn   (MemWrEn),
      .MemWrData (MemWrData)
   );

   assign MemRdData = mem[MemAddr];

   function automatic int isqrt(input int x);
      int r = 0;
      while ((r + 1) * (r + 1) <= x) r++;
      return r;
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // data memory write port
   always @(posedge Clk) begin
      if (MemWrEn) begin
         mem[MemAddr] = MemWrData;
         wr_count++;
      end
   end

   // launch/timing reference: 11 cycles from launch edge to Ack, launches ignored while running
   always @(posedge Clk) begin
      cyc++;
      if (!Reset) begin
         m_run = 1'b0;
         m_ack = 1'b0;
         m_start_prev = 1'b0;
         m_n = 0;
      end else begin
         if (Start && !m_start_prev && !m_run) begin
            m_run  = 1'b1;
            m_ack  = 1'b0;
            m_n    = 0;
            m_root = isqrt(int'({mem[OPND_ADDR], mem[OPND_ADDR + 1]}));
         end else if (m_run) begin
            m_n++;
            if (m_n == 11) begin
               m_run = 1'b0;
               m_ack = 1'b1;
            end
         end
         m_start_prev = Start;
      end
      m_valid = 1'b1;
   end

   // Ack rising-edge timestamp
   always @(posedge Clk) begin
      #1;
      if (Ack && !ack_prev) ack_rise_cyc = cyc;
      ack_prev = Ack;
   end

   // per-cycle compare against the reference
   always @(negedge Clk) begin
      int exp_addr;
      bit exp_wr;
      if (m_valid) begin
         exp_addr = 0;
         exp_wr   = 1'b0;
         if (m_run) begin
            if (m_n == 0) exp_addr = OPND_ADDR;
            else if (m_n == 1) exp_addr = OPND_ADDR + 1;
            else if (m_n == 10) begin
               exp_addr = RES_ADDR;
               exp_wr   = 1'b1;
            end
         end
         chk("busy", int'(Busy), int'(m_run));
         chk("ack", int'(Ack), int'(m_ack));
         chk("wr_en", int'(MemWrEn), int'(exp_wr));
         chk("addr", int'(MemAddr), exp_addr);
         if (exp_wr) chk("wr_data", int'(MemWrData), m_root);
      end
   end

   // wait for Ack to rise after a launch at launch_idx, then check latency
   task automatic wait_ack(input string name, input int launch_idx, input bit hold,
                           input int glitch, output bit got);
      got = 1'b0;
      for (int i = 1; i <= 40 && !got; i++) begin
         @(negedge Clk);
         if (i == 1) begin
            chk({name, "_ack_drop"}, int'(Ack), 0);
            chk({name, "_busy_up"}, int'(Busy), 1);
         end
         if (!hold && i == 2) Start = 1'b0;
         if (glitch != 0 && i == glitch) Start = 1'b1;
         if (glitch != 0 && i == glitch + 1) Start = 1'b0;
         if (ack_rise_cyc != 0) got = 1'b1;
      end
      chk({name, "_timeout"}, int'(got), 1);
      if (got) chk({name, "_latency"}, ack_rise_cyc - launch_idx, 11);
   endtask

   task automatic run_op(input string name, input int op, input int exp,
                         input int glitch, input bit hold);
      int w0;
      int launch_idx;
      bit got;
      mem[OPND_ADDR]     = 8'(op >> 8);
      mem[OPND_ADDR + 1] = 8'(op);
      w0 = wr_count;
      @(negedge Clk);
      Start = 1'b1;
      launch_idx = cyc + 1;
      ack_rise_cyc = 0;
      wait_ack(name, launch_idx, hold, glitch, got);
      if (got) begin
         chk({name, "_result"}, int'(mem[RES_ADDR]), exp);
         chk({name, "_writes"}, wr_count - w0, 1);
      end
   endtask

   initial begin
      int w;
      int op;
      int launch_idx;
      bit got;
      for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
      Reset = 1'b0;
      Start = 1'b0;
      repeat (3) @(negedge Clk);
      chk("rst_ack", int'(Ack), 0);
      chk("rst_busy", int'(Busy), 0);
      chk("rst_addr", int'(MemAddr), 0);
      chk("rst_wr_en", int'(MemWrEn), 0);
      chk("rst_wr_data", int'(MemWrData), 0);
      Reset = 1'b1;
      repeat (2) @(negedge Clk);

      // pinned operands, back-to-back relaunches from DONE
      run_op("op9000", 36864, 8'hC0, 0, 1'b0);
      run_op("opFFFF", 65535, 8'hFF, 0, 1'b0);
      run_op("opFE01", 65025, 8'hFF, 0, 1'b0);
      run_op("opFE00", 65024, 8'hFE, 0, 1'b0);
      run_op("op2", 2, 8'h01, 0, 1'b0);
      run_op("op1", 1, 8'h01, 0, 1'b0);
      run_op("op0", 0, 8'h00, 0, 1'b0);

      // second Start edge mid-CALC is ignored
      run_op("glitch", 50000, 223, 7, 1'b0);

      // Start held high through completion: one computation only
      w = wr_count;
      run_op("hold", 10000, 100, 0, 1'b1);
      repeat (20) @(negedge Clk);
      chk("hold_ack_stays", int'(Ack), 1);
      chk("hold_one_write", wr_count - w, 1);
      Start = 1'b0;
      repeat (2) @(negedge Clk);

      // reset during CALC: no write, back to idle
      mem[RES_ADDR] = 8'h5A;
      mem[OPND_ADDR] = 8'hFF;
      mem[OPND_ADDR + 1] = 8'hFF;
      w = wr_count;
      @(negedge Clk);
      Start = 1'b1;
      repeat (2) @(negedge Clk);
      Start = 1'b0;
      repeat (4) @(negedge Clk);
      chk("mid_busy_pre", int'(Busy), 1);
      Reset = 1'b0;
      @(negedge Clk);
      chk("mid_rst_busy", int'(Busy), 0);
      chk("mid_rst_ack", int'(Ack), 0);
      repeat (3) @(negedge Clk);
      Reset = 1'b1;
      repeat (15) @(negedge Clk);
      chk("mid_rst_mem", int'(mem[RES_ADDR]), 8'h5A);
      chk("mid_rst_writes", wr_count - w, 0);
      chk("mid_rst_ack_after", int'(Ack), 0);

      // Start high during reset launches on the first cycle after release
      mem[OPND_ADDR] = 8'h01;
      mem[OPND_ADDR + 1] = 8'h00;
      @(negedge Clk);
      Reset = 1'b0;
      Start = 1'b1;
      repeat (2) @(negedge Clk);
      Reset = 1'b1;
      launch_idx = cyc + 1;
      ack_rise_cyc = 0;
      wait_ack("rst_start", launch_idx, 1'b0, 0, got);
      if (got) chk("rst_start_result", int'(mem[RES_ADDR]), 16);

      // randomized operands with occasional ignored Start edges while busy
      for (int k = 0; k < 16; k++) begin
         case (k % 4)
            0: op = int'($urandom_range(0, 255));
            1: op = int'($urandom_range(65000, 65535));
            default: op = int'($urandom_range(0, 65535));
         endcase
         run_op("rand", op, isqrt(op),
                ($urandom_range(0, 1) == 1) ? int'($urandom_range(4, 8)) : 0, 1'b0);
      end

      repeat (3) @(negedge Clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/sqrt_engine.md
Name: sqrt_engine

Overview:
- Hardware responder for the Start/Ack program-launch handshake.
- On a Start rising edge it reads a 16-bit operand from data memory: high byte at OPND_ADDR, low byte at OPND_ADDR+1.
- It computes floor(sqrt(operand)) digit-by-digit, writes the 8-bit root to RES_ADDR, then raises Ack.
- Sits beside the data memory as a memory-port master; the bench loads the operand, pulses Start, waits on Ack and reads the result byte.

Parameters:
- AW, 8, data-memory address width.
- DW, 8, data-memory word width (fixed at 8; operand is two words).
- OPND_ADDR, 16, address of operand high byte; low byte at OPND_ADDR+1.
- RES_ADDR, 18, address written with the 8-bit root.

Ports:
- Clk  in  1  single clock, all state updates on rising edge.
- Reset  in  1  synchronous, active-low reset.
- Start  in  1  launch request; level input, rising edge launches.
- Ack  out  1  done flag; level, held high until the next launch.
- Busy  out  1  high from launch until the result write completes.
- MemAddr  out  AW  data-memory address.
- MemRdData  in  DW  combinational read data for MemAddr, valid in the same cycle.
- MemWrEn  out  1  write strobe; one cycle.
- MemWrData  out  DW  write data.

Behaviour:
- Reset (Reset==0 at an edge) sets:
  - state=IDLE, Ack=0, Busy=0, MemWrEn=0, MemAddr=0, MemWrData=0;
  - start_q=0, root=0, rem=0, opnd=0, iteration count=0.
- Launch = Start & ~start_q, where start_q is Start registered every cycle.
  - Start held high across reset release therefore launches exactly once.
- States:
  - IDLE: on launch -> RD_HI (Busy=1).
  - RD_HI: MemAddr=OPND_ADDR; latch opnd[15:8]=MemRdData -> RD_LO.
  - RD_LO: MemAddr=OPND_ADDR+1; latch opnd[7:0]; clear root/rem; count=7 -> CALC.
  - CALC: one digit per cycle, 8 cycles, count 7..0 -> WRITE after count==0.
  - WRITE: MemAddr=RES_ADDR, MemWrData=root, MemWrEn=1 for exactly this cycle -> DONE.
  - DONE: Ack=1, Busy=0. A launch here clears Ack on the next edge and enters RD_HI.
- Digit step (unsigned):
  - rem is 10 bits, root is 8 bits.
  - r' = (rem<<2) | opnd[2*count+1 : 2*count]; t = (root<<2) | 1.
  - If r' >= t: rem = r' - t, root = (root<<1) | 1. Else: rem = r', root = root<<1.
- Result is floor (truncating), never rounded; 0 yields 0 with no special path.
- Latency: from the edge sampling the launch to the edge setting Ack is 11 cycles (2 reads + 8 steps + 1 write).
- A launch edge while Busy is ignored: no restart, no queueing.
- Reset mid-operation: returns to IDLE, no memory write issued, Ack=0.
- MemAddr is 0 and MemWrEn is 0 outside RD_HI/RD_LO/WRITE.
- Memory is never written except in WRITE.

Decomposition:
- Package sqrt_pkg holds:
  - state enum (IDLE, RD_HI, RD_LO, CALC, WRITE, DONE);
  - default address constants;
  - REM_W=10, ROOT_W=8, N_STEPS=8.
- Sub-module sqrt_step (combinational): inputs rem, root, 2-bit operand pair; outputs next rem, next root. Instantiated once inside the CALC datapath.

Test Plan:
- Operand 36864 (0x9000) in mem[16]=0x90, mem[17]=0x00; Start pulse of 2 cycles -> mem[18]=0xC0 (192), Ack high 11 cycles after launch edge, MemWrEn high exactly one cycle.
- Operands 65535 -> 0xFF; 65025 -> 0xFF; 65024 -> 0xFE; 2 -> 0x01; 1 -> 0x01; 0 -> 0x00, each run back-to-back via new Start edges; Ack drops the cycle after each relaunch.
- Start held high continuously through and after completion -> exactly one computation, one write, Ack stays high.
- Second Start edge at cycle 5 of CALC -> ignored; result and timing identical to a single launch.
- Reset driven low during CALC -> next cycle state IDLE, Ack=0, Busy=0; mem[18] unchanged from its preloaded value (e.g. 0x5A).
- Start high while Reset low, then Reset released -> launch occurs on the first cycle after release and completes normally.
